// File: rtl/nxn_game_core.sv
// SIZE x SIZE board-game engine: move legality, turn order, and a 4-cycle
// directional scan around the last move for WIN_LEN-in-a-row or draw.
module nxn_game_core #(
  parameter int SIZE      = 3,
  parameter int WIN_LEN   = 3,
  parameter int COORD_W   = 3,
  parameter int ALT_START = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     new_game,
  input  logic                     move_valid,
  input  logic [COORD_W-1:0]       move_row,
  input  logic [COORD_W-1:0]       move_col,
  output logic                     move_ready,
  output logic                     move_reject,
  output logic [2*SIZE*SIZE-1:0]   board,
  output logic [1:0]               cur_player,
  output logic [1:0]               game_state,
  output logic [1:0]               winner,
  output logic [6:0]               move_count,
  output logic [6:0]               last_idx
);

  localparam int CELLS = SIZE * SIZE;
  localparam logic [COORD_W:0] SIZE_C  = SIZE[COORD_W:0];
  localparam logic [6:0]       CELLS_C = CELLS[6:0];

  localparam logic [1:0] ST_PLAY  = 2'b00;
  localparam logic [1:0] ST_CHECK = 2'b01;
  localparam logic [1:0] ST_OVER  = 2'b10;

  localparam logic [1:0] P1   = 2'b01;
  localparam logic [1:0] P2   = 2'b10;
  localparam logic [1:0] DRAW = 2'b11;

  logic [2*CELLS-1:0] board_q, board_d;
  logic [1:0]         cur_player_q, cur_player_d;
  logic [1:0]         state_q, state_d;
  logic [1:0]         winner_q, winner_d;
  logic [6:0]         move_count_q, move_count_d;
  logic [6:0]         last_idx_q, last_idx_d;
  logic               move_reject_q, move_reject_d;
  logic [1:0]         start_q, start_d;
  logic [1:0]         dir_q, dir_d;
  logic               hit_q, hit_d;
  logic [COORD_W-1:0] last_row_q, last_row_d;
  logic [COORD_W-1:0] last_col_q, last_col_d;

  function automatic logic in_board(input int r, input int c);
    return (r >= 0) && (r < SIZE) && (c >= 0) && (c < SIZE);
  endfunction

  function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int r, input int c);
    logic [2*CELLS-1:0] sh;
    sh = b >> (2 * (r * SIZE + c));
    return sh[1:0];
  endfunction

  // Stepping in row/col space (not flat index) so runs never wrap across rows.
  logic hit_now;
  always_comb begin
    int dr, dc, r, c, fwd, bwd, base_r, base_c;
    logic run;
    case (dir_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    base_r = int'(last_row_q);
    base_c = int'(last_col_q);
    fwd = 0;
    run = 1'b1;
    for (int unsigned k = 1; k < WIN_LEN; k++) begin
      r = base_r + int'(k) * dr;
      c = base_c + int'(k) * dc;
      if (run && in_board(r, c) && cell_at(board_q, r, c) == cur_player_q) fwd = fwd + 1;
      else run = 1'b0;
    end
    bwd = 0;
    run = 1'b1;
    for (int unsigned k = 1; k < WIN_LEN; k++) begin
      r = base_r - int'(k) * dr;
      c = base_c - int'(k) * dc;
      if (run && in_board(r, c) && cell_at(board_q, r, c) == cur_player_q) bwd = bwd + 1;
      else run = 1'b0;
    end
    hit_now = (1 + fwd + bwd) >= WIN_LEN;
  end

  logic       in_range;
  logic [6:0] acc_idx;
  logic [1:0] target;
  always_comb begin
    in_range = ({1'b0, move_row} < SIZE_C) && ({1'b0, move_col} < SIZE_C);
    acc_idx  = 7'(move_row) * 7'(SIZE) + 7'(move_col);
    target   = cell_at(board_q, int'(move_row), int'(move_col));
  end

  always_comb begin
    board_d       = board_q;
    cur_player_d  = cur_player_q;
    state_d       = state_q;
    winner_d      = winner_q;
    move_count_d  = move_count_q;
    last_idx_d    = last_idx_q;
    move_reject_d = 1'b0;
    start_d       = start_q;
    dir_d         = dir_q;
    hit_d         = hit_q;
    last_row_d    = last_row_q;
    last_col_d    = last_col_q;
    if (new_game) begin
      board_d      = '0;
      state_d      = ST_PLAY;
      winner_d     = '0;
      move_count_d = '0;
      last_idx_d   = '0;
      dir_d        = '0;
      hit_d        = 1'b0;
      if (ALT_START != 0) begin
        start_d      = (start_q == P1) ? P2 : P1;
        cur_player_d = start_d;
      end else begin
        cur_player_d = P1;
      end
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (move_valid) begin
            if (in_range && target == 2'b00) begin
              for (int unsigned i = 0; i < CELLS; i++)
                if (acc_idx == 7'(i)) board_d[2*i +: 2] = cur_player_q;
              move_count_d = move_count_q + 7'd1;
              last_idx_d   = acc_idx;
              last_row_d   = move_row;
              last_col_d   = move_col;
              state_d      = ST_CHECK;
              dir_d        = '0;
              hit_d        = 1'b0;
            end else begin
              move_reject_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          hit_d = hit_q | hit_now;
          dir_d = dir_q + 2'd1;
          if (dir_q == 2'd3) begin
            if (hit_d) begin
              state_d  = ST_OVER;
              winner_d = cur_player_q;
            end else if (move_count_q == CELLS_C) begin
              state_d  = ST_OVER;
              winner_d = DRAW;
            end else begin
              state_d      = ST_PLAY;
              cur_player_d = (cur_player_q == P1) ? P2 : P1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      board_q       <= '0;
      cur_player_q  <= P1;
      state_q       <= ST_PLAY;
      winner_q      <= '0;
      move_count_q  <= '0;
      last_idx_q    <= '0;
      move_reject_q <= 1'b0;
      start_q       <= P1;
      dir_q         <= '0;
      hit_q         <= 1'b0;
      last_row_q    <= '0;
      last_col_q    <= '0;
    end else begin
      board_q       <= board_d;
      cur_player_q  <= cur_player_d;
      state_q       <= state_d;
      winner_q      <= winner_d;
      move_count_q  <= move_count_d;
      last_idx_q    <= last_idx_d;
      move_reject_q <= move_reject_d;
      start_q       <= start_d;
      dir_q         <= dir_d;
      hit_q         <= hit_d;
      last_row_q    <= last_row_d;
      last_col_q    <= last_col_d;
    end
  end

  assign move_ready  = (state_q == ST_PLAY) && !new_game;
  assign move_reject = move_reject_q;
  assign board       = board_q;
  assign cur_player  = cur_player_q;
  assign game_state  = state_q;
  assign winner      = winner_q;
  assign move_count  = move_count_q;
  assign last_idx    = last_idx_q;

endmodule

// File: tb/tb_nxn_game_core.sv
// Bench for nxn_game_core: a 3x3 alternating-start instance and a 5x5 four-in-a-row
// instance, each checked every cycle against a board-level game model.
module tb_nxn_game_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           ng, mv;
  logic [1:0][2:0]      mr, mc;
  logic [1:0]           rdy, rej;
  logic [1:0][1:0]      cp, gs, wn;
  logic [1:0][6:0]      cnt, li;
  logic [17:0]          b0;
  logic [49:0]          b1;

  int tests = 0;
  int fails = 0;

  nxn_game_core #(.SIZE(3), .WIN_LEN(3), .COORD_W(3), .ALT_START(1)) dut0 (
    .clock(clk), .reset(rst), .new_game(ng[0]), .move_valid(mv[0]),
    .move_row(mr[0]), .move_col(mc[0]), .move_ready(rdy[0]), .move_reject(rej[0]),
    .board(b0), .cur_player(cp[0]), .game_state(gs[0]), .winner(wn[0]),
    .move_count(cnt[0]), .last_idx(li[0]));

  nxn_game_core #(.SIZE(5), .WIN_LEN(4), .COORD_W(3), .ALT_START(0)) dut1 (
    .clock(clk), .reset(rst), .new_game(ng[1]), .move_valid(mv[1]),
    .move_row(mr[1]), .move_col(mc[1]), .move_ready(rdy[1]), .move_reject(rej[1]),
    .board(b1), .cur_player(cp[1]), .game_state(gs[1]), .winner(wn[1]),
    .move_count(cnt[1]), .last_idx(li[1]));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- game model ----------------
  int mb[2][8][8];
  int mcp[2], mst[2], mwin[2], mcnt[2], mlast[2], mrej[2], mstart[2], mleft[2];
  bit armed = 1'b0;

  function automatic int nsz(input int u);
    return (u == 0) ? 3 : 5;
  endfunction

  function automatic int nwin(input int u);
    return (u == 0) ? 3 : 4;
  endfunction

  // Any WIN_LEN run of player p anywhere on the board.
  function automatic bit has_line(input int u, input int p);
    int n, w, rr, cc;
    bit ok;
    int drs[4] = '{0, 1, 1, 1};
    int dcs[4] = '{1, 0, 1, -1};
    n = nsz(u);
    w = nwin(u);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          ok = 1'b1;
          for (int k = 0; k < w; k++) begin
            rr = r + k * drs[d];
            cc = c + k * dcs[d];
            if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
            else if (mb[u][rr][cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int n;
      n = nsz(u);
      mrej[u] <= 0;
      if (rst) begin
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mb[u][r][c] <= 0;
        mcp[u] <= 1; mst[u] <= 0; mwin[u] <= 0; mcnt[u] <= 0; mlast[u] <= 0;
        mstart[u] <= 1; mleft[u] <= 0;
        armed <= 1'b1;
      end else if (ng[u]) begin
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mb[u][r][c] <= 0;
        mst[u] <= 0; mwin[u] <= 0; mcnt[u] <= 0; mlast[u] <= 0;
        if (u == 0) begin
          mstart[u] <= 3 - mstart[u];
          mcp[u]    <= 3 - mstart[u];
        end else begin
          mcp[u] <= 1;
        end
      end else if (mst[u] == 0) begin
        if (mv[u]) begin
          if (mr[u] < n && mc[u] < n && mb[u][mr[u]][mc[u]] == 0) begin
            mb[u][mr[u]][mc[u]] <= mcp[u];
            mcnt[u]  <= mcnt[u] + 1;
            mlast[u] <= mr[u] * n + mc[u];
            mst[u]   <= 1;
            mleft[u] <= 4;
          end else begin
            mrej[u] <= 1;
          end
        end
      end else if (mst[u] == 1) begin
        if (mleft[u] > 1) mleft[u] <= mleft[u] - 1;
        else if (has_line(u, mcp[u])) begin
          mst[u] <= 2; mwin[u] <= mcp[u];
        end else if (mcnt[u] == n * n) begin
          mst[u] <= 2; mwin[u] <= 3;
        end else begin
          mst[u] <= 0; mcp[u] <= 3 - mcp[u];
        end
      end
    end
  end

  logic [127:0] exp_b, act_b;
  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        exp_b = '0;
        for (int r = 0; r < nsz(u); r++)
          for (int c = 0; c < nsz(u); c++)
            exp_b[2*(r*nsz(u)+c) +: 2] = 2'(mb[u][r][c]);
        act_b = (u == 0) ? {110'b0, b0} : {78'b0, b1};
        chk($sformatf("u%0d move_ready", u), rdy[u], (mst[u] == 0 && !ng[u]));
        chk($sformatf("u%0d move_reject", u), rej[u], mrej[u]);
        chk($sformatf("u%0d cur_player", u), cp[u], mcp[u]);
        chk($sformatf("u%0d game_state", u), gs[u], mst[u]);
        chk($sformatf("u%0d winner", u), wn[u], mwin[u]);
        chk($sformatf("u%0d move_count", u), cnt[u], mcnt[u]);
        chk($sformatf("u%0d last_idx", u), li[u], mlast[u]);
        chk($sformatf("u%0d board", u), act_b, exp_b);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mv_do(input int u, input int r, input int c);
    mv[u] = 1'b1;
    mr[u] = 3'(r);
    mc[u] = 3'(c);
    tick(1);
    mv[u] = 1'b0;
  endtask

  task automatic play(input int u, input int r, input int c);
    mv_do(u, r, c);
    tick(4);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ng = '0; mv = '0; mr = '0; mc = '0;
    tick(2);
    rst = 1'b0;
    chk("reset cur_player", cp[0], 2'b01);
    chk("reset state", gs[0], 2'b00);
    chk("reset board", b0, 18'h0);
    chk("reset ready", rdy[1], 1'b1);

    // Row 0 win by P1
    play(0, 0, 0); play(0, 1, 0); play(0, 0, 1); play(0, 1, 1); play(0, 0, 2);
    chk("row win state", gs[0], 2'b10);
    chk("row win winner", wn[0], 2'b01);
    chk("row win count", cnt[0], 7'd5);
    chk("row win board", b0, 18'h00295);
    chk("row win ready", rdy[0], 1'b0);

    // Anti-diagonal wins
    do_reset;
    play(0, 0, 2); play(0, 0, 0); play(0, 1, 1); play(0, 0, 1); play(0, 2, 0);
    chk("anti1 winner", wn[0], 2'b01);
    do_reset;
    play(0, 0, 2); play(0, 1, 0); play(0, 1, 1); play(0, 2, 2); play(0, 2, 0);
    chk("anti2 winner", wn[0], 2'b01);
    chk("anti2 last_idx", li[0], 7'd6);

    // Full-board draw, then a move in OVER is ignored
    do_reset;
    play(0, 0, 0); play(0, 0, 1); play(0, 0, 2); play(0, 1, 1); play(0, 1, 0);
    play(0, 1, 2); play(0, 2, 1); play(0, 2, 0); play(0, 2, 2);
    chk("draw count", cnt[0], 7'd9);
    chk("draw winner", wn[0], 2'b11);
    mv_do(0, 0, 0);
    chk("over no reject", rej[0], 1'b0);
    chk("over board frozen", b0, 18'h16A59);

    // Occupied and out-of-range rejects
    do_reset;
    play(0, 1, 1);
    mv_do(0, 1, 1);
    chk("occupied reject", rej[0], 1'b1);
    chk("occupied cur_player", cp[0], 2'b10);
    chk("occupied board", b0, 18'h00100);
    tick(1);
    chk("reject one cycle", rej[0], 1'b0);
    mv_do(0, 3, 0);
    chk("range reject", rej[0], 1'b1);
    tick(1);

    // Flat indices 1,2,3 are consecutive but not a row
    do_reset;
    play(0, 0, 1); play(0, 2, 2); play(0, 0, 2); play(0, 2, 0); play(0, 1, 0);
    chk("wrap state", gs[0], 2'b00);
    chk("wrap winner", wn[0], 2'b00);

    // new_game in the second CHECK cycle, alternating starter
    do_reset;
    mv_do(0, 0, 0);
    tick(1);
    ng[0] = 1'b1;
    chk("ng ready low", rdy[0], 1'b0);
    tick(1);
    ng[0] = 1'b0;
    chk("ng board", b0, 18'h0);
    chk("ng state", gs[0], 2'b00);
    chk("ng winner", wn[0], 2'b00);
    chk("ng alt cur_player", cp[0], 2'b10);
    ng[0] = 1'b1;
    tick(1);
    ng[0] = 1'b0;
    chk("ng2 alt cur_player", cp[0], 2'b01);
    play(0, 2, 2);
    chk("ng2 mover mark", b0, 18'h10000);

    // 5x5, four in a row on the main diagonal
    do_reset;
    play(1, 1, 1); play(1, 0, 4); play(1, 2, 2); play(1, 4, 0); play(1, 3, 3);
    chk("5x5 three state", gs[1], 2'b00);
    chk("5x5 three winner", wn[1], 2'b00);
    play(1, 0, 3); play(1, 4, 4);
    chk("5x5 four state", gs[1], 2'b10);
    chk("5x5 four winner", wn[1], 2'b01);
    chk("5x5 last_idx", li[1], 7'd24);
    ng[1] = 1'b1;
    tick(1);
    ng[1] = 1'b0;
    chk("5x5 ng cur_player", cp[1], 2'b01);
    mv_do(1, 5, 0);
    chk("5x5 range reject", rej[1], 1'b1);
    play(1, 2, 2);
    mv_do(1, 2, 3);
    do_reset;
    chk("mid reset state", gs[1], 2'b00);
    chk("mid reset board", b1, 50'h0);
    chk("mid reset count", cnt[1], 7'd0);
    chk("mid reset cur_player", cp[1], 2'b01);
    chk("mid reset last_idx", li[1], 7'd0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nxn_game_core.md
Name: nxn_game_core

Overview:
- Parametrised board-game engine; generalises the fixed 3x3 tic-tac-toe grid (nine 2-bit cells) to a SIZE x SIZE board with WIN_LEN-in-a-row detection.
- Accepts moves from the keypad decoder, enforces turns and legality, and detects win or draw.
- Exports the flattened board to the VGA and dot-matrix renderers, and status to the seven-segment driver.

Parameters:
- SIZE, 3, board edge length (3..8).
- WIN_LEN, 3, consecutive marks needed to win (2..SIZE).
- COORD_W, 3, width of the row/col coordinate buses; must satisfy 2^COORD_W >= SIZE.
- ALT_START, 0, when 1 the starting player alternates on each new_game; when 0, player 1 always starts.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- new_game  in  1  single-cycle request to clear the board and start a new game.
- move_valid  in  1  move request strobe.
- move_row  in  COORD_W  target row, 0 = top.
- move_col  in  COORD_W  target column, 0 = left.
- move_ready  out  1  high only in PLAY.
- move_reject  out  1  one-cycle pulse on an illegal move.
- board  out  2*SIZE*SIZE  cell idx = row*SIZE+col occupies bits [2*idx+1:2*idx]; 00 empty, 01 player 1, 10 player 2; 11 is never written.
- cur_player  out  2  player to move: 01 or 10.
- game_state  out  2  00 PLAY, 01 CHECK, 10 OVER.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw.
- move_count  out  7  number of marks on the board.
- last_idx  out  7  index of the most recently accepted cell.

Behaviour:
- Reset (synchronous, active-high), applied at the next clock edge:
  - board all 0, cur_player=01, state PLAY, winner=00, move_count=0, last_idx=0, move_reject=0.
  - start-player register = 01.
- Priority: reset > new_game > move handling.
- new_game:
  - Accepted in any state, including mid-CHECK; any CHECK in progress is aborted.
  - Next cycle: board cleared, move_count=0, winner=00, state PLAY, last_idx=0.
  - ALT_START=1: start-player register toggles and cur_player takes the new value. ALT_START=0: cur_player=01.
- PLAY, move_valid=1, coordinates in range (< SIZE) and target cell 00 (accept):
  - Next edge: cell := cur_player, move_count+1, last_idx := idx, state CHECK.
- PLAY, move_valid=1, out of range or target occupied (reject):
  - Next cycle: move_reject=1 for exactly one cycle; no other state changes.
- move_valid while state is CHECK or OVER: ignored, no reject pulse.
- CHECK: exactly 4 cycles, direction counter d = 0 horizontal, 1 vertical, 2 diagonal (down-right), 3 anti-diagonal (down-left).
  - Each cycle, combinationally count consecutive cells equal to the mover's mark, stepping away from last_idx in both senses along d.
  - Each sense inspects at most WIN_LEN-1 cells and stops at the board edge or at the first non-matching cell.
  - Line length = 1 + both counts. A sticky hit flag is set if length >= WIN_LEN.
- CHECK exit (after cycle d=3), evaluated on the next edge:
  - hit: state OVER, winner=mover.
  - no hit and move_count==SIZE*SIZE: state OVER, winner=11 (a win on the last cell takes precedence over draw).
  - otherwise: state PLAY, cur_player toggles 01<->10.
- Accept-to-ready latency is 5 cycles: 1 write cycle + 4 check cycles.
- OVER: board frozen, cur_player holds the mover's value, move_ready=0. OVER is left only by new_game or reset.
- move_ready = (state==PLAY) && !new_game.
- Edge handling: coordinate stepping must never wrap across a row boundary. For example, with SIZE=3, idx 2 to the right is off-board, not idx 3.

Test Plan:
- SIZE=3: P1 (0,0), P2 (1,0), P1 (0,1), P2 (1,1), P1 (0,2) -> 5 cycles after the last accept, state=OVER, winner=01, move_count=5, board=18'h00015 | (P2 bits at idx 3 and 4).
- SIZE=3: P1 (0,2), (1,1), (2,0) anti-diagonal, with P2 at (0,0), (0,1) -> winner=01. Also check P1 at (0,2), P2 at (1,0), P1 at (1,1), P2 at (2,2), P1 at (2,0) -> winner=01.
- SIZE=3 full-board draw, sequence (0,0) (0,1) (0,2) (1,1) (1,0) (1,2) (2,1) (2,0) (2,2) -> move_count=9, winner=11; a move_valid afterwards produces no move_reject and no board change.
- SIZE=3, P1 (1,1) then P2 (1,1) -> one-cycle move_reject, cur_player stays 10, board unchanged. Then move_row=3 -> reject. Also the horizontal-wrap case: P1 marks at (0,1), (0,2), (1,0) -> no win.
- new_game asserted during the second CHECK cycle -> next cycle board=0, state PLAY, winner=00. With ALT_START=1, cur_player=10, and =01 after a second new_game.
- SIZE=5, WIN_LEN=4: P1 (1,1), (2,2), (3,3), then (4,4) with P2 moves elsewhere -> no win after 3 in a row, winner=01 after the 4th. A reset mid-game returns all outputs to their reset values.
